// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a (start address, beat count) command into INCR bursts and streams the beats out.
// Define AXI_RD_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module axi_burst_reader #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              done,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic              m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    logic [LEN_W-1:0]  beats_left;
    logic [8:0]        beat_cnt;
    logic [8:0]        burst;
    logic [ADDR_W-1:0] nxt_addr;
    logic [LEN_W-1:0]  nxt_left;
    logic [8:0]        nxt_burst;
    logic              beat;
    logic              last_of_burst;
`ifdef AXI_RD_4K_SPLIT_EN
    logic [12:0]       room;
    logic [12:0]       room_beats;
`endif

    assign m_axi_arid    = 1'b0;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    // R channel is a straight pass-through so out_ready alone throttles the memory.
    assign out_valid     = (state == DATA) && m_axi_rvalid;
    assign m_axi_rready  = (state == DATA) && out_ready;
    assign out_data      = m_axi_rdata;
    assign out_last      = (state == DATA) && (beats_left == LEN_W'(1));
    assign beat          = out_valid && out_ready;
    assign last_of_burst = (beat_cnt == 9'd1);

    // Address and length of the burst that would be issued next: from the
    // command while idle, from the running position at the end of a burst.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        nxt_addr = {cmd_addr[ADDR_W-1:SIZE], SIZE'(0)};
        nxt_left = cmd_len;
        if (state == DATA) begin
            nxt_addr = m_axi_araddr + (ADDR_W'(burst) << SIZE);
            nxt_left = beats_left - LEN_W'(1);
        end
        if (32'(nxt_left) > 32'(MAX_BURST)) nxt_burst = 9'(MAX_BURST);
        else                                nxt_burst = 9'(nxt_left);
`ifdef AXI_RD_4K_SPLIT_EN
        room       = 13'h1000 - {1'b0, nxt_addr[11:0]};
        room_beats = room >> SIZE;
        if ({4'b0, nxt_burst} > room_beats) nxt_burst = room_beats[8:0];
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            beats_left    <= '0;
            beat_cnt      <= '0;
            burst         <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        err <= 1'b0;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            beats_left    <= cmd_len;
                            state         <= ADDR;
                            cmd_ready     <= 1'b0;
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= nxt_addr;
                            m_axi_arlen   <= 8'(nxt_burst - 9'd1);
                            burst         <= nxt_burst;
                        end
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        beat_cnt      <= burst;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt   <= beat_cnt - 9'd1;
                        beats_left <= beats_left - LEN_W'(1);
                        // Protocol violations are flagged but the data keeps flowing.
                        if ((m_axi_rlast != last_of_burst) || (m_axi_rresp != 2'b00)) err <= 1'b1;
                        if (last_of_burst) begin
                            if (beats_left == LEN_W'(1)) begin
                                done      <= 1'b1;
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                            end else begin
                                state         <= ADDR;
                                m_axi_arvalid <= 1'b1;
                                m_axi_araddr  <= nxt_addr;
                                m_axi_arlen   <= 8'(nxt_burst - 9'd1);
                                burst         <= nxt_burst;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, m_axi_rid, cmd_addr[SIZE-1:0]};

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: random-latency AXI memory model, randomly stalling sink,
// and a page/burst-splitting reference model built from plain address arithmetic.
`timescale 1ns/1ps
module tb_axi_burst_reader;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 16;
    localparam int BYTES     = DATA_W / 8;

    logic              clk, resetn;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              done, err;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;
    logic              m_axi_arid, m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize, m_axi_arprot;
    logic [1:0]        m_axi_arburst, m_axi_rresp;
    logic [3:0]        m_axi_arcache, m_axi_arqos;
    logic              m_axi_rid, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata;

    axi_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    int n_checks = 0;
    int n_pass   = 0;

    ar_t               ar_q[$], exp_ar[$];
    logic [DATA_W-1:0] got_data[$], exp_data[$];
    logic              got_last[$];
    int  cyc = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0, cmd_beat = 0;
    int  inj_resp_idx = -1, inj_last_idx = -1, bp_cnt = 0, bp_leak = 0;
    bit  saw_arvalid = 0;

    // Memory contents: every 32-bit lane a distinct scramble of its byte address.
    function automatic logic [DATA_W-1:0] mem_word(input logic [31:0] a);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++)
            w[k*32 +: 32] = ((a + 32'(k * 4)) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
        return w;
    endfunction

    // Reference: chop the request into bursts of at most MAX_BURST beats (and, with
    // the page rule, never past the next 4 KB boundary); beats are consecutive words.
    function automatic void build_expect(input logic [31:0] a0, input int len);
        logic [31:0] a;
        int left, b;
        exp_ar.delete();
        exp_data.delete();
        a = a0 & ~32'(BYTES - 1);
        for (int i = 0; i < len; i++) exp_data.push_back(mem_word(a + 32'(i * BYTES)));
        left = len;
        while (left > 0) begin
            b = (left < MAX_BURST) ? left : MAX_BURST;
`ifdef AXI_RD_4K_SPLIT_EN
            if (b > (4096 - int'(a % 4096)) / BYTES) b = (4096 - int'(a % 4096)) / BYTES;
`endif
            exp_ar.push_back({a, 8'(b - 1)});
            a += 32'(b * BYTES);
            left -= b;
        end
    endfunction

    // AXI slave + output sink. Drives at the falling edge, then records handshakes
    // that the next rising edge will complete.
    initial begin : slave
        logic [31:0] s_addr, hold_addr;
        logic [7:0]  hold_len;
        int  s_left;
        bit  s_active, s_pending, s_hold, bp_on, ar_wait;
        s_addr = 0; s_left = 0; s_active = 0; s_pending = 0; s_hold = 0; ar_wait = 0;
        hold_addr = 0; hold_len = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
        m_axi_rresp = 0; m_axi_rid = 0; out_ready = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                s_active = 0; s_pending = 0; s_hold = 0; ar_wait = 0;
                continue;
            end
            if (s_pending) begin s_active = 1; s_pending = 0; end
            if (bp_cnt > 0) begin out_ready = 0; bp_cnt--; bp_on = 1; end
            else begin out_ready = ($urandom_range(0, 3) != 0); bp_on = 0; end
            m_axi_arready = m_axi_arvalid && !s_active && !s_pending && ($urandom_range(0, 2) != 0);
            if (!s_hold) begin
                if (s_active && $urandom_range(0, 3) != 0) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem_word(s_addr);
                    m_axi_rlast  = (s_left == 1) ^ (cmd_beat == inj_last_idx);
                    m_axi_rresp  = (cmd_beat == inj_resp_idx) ? 2'b10 : 2'b00;
                    s_hold = 1;
                end else begin
                    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
                end
            end
            #1;
            if (bp_on && m_axi_rready) bp_leak++;
            if (m_axi_arvalid) saw_arvalid = 1;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (ar_wait) begin
                n_checks++;
                if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== {1'b1, hold_addr, hold_len})
                    $display("FAIL ar_stable: got valid=%b addr=%h len=%0d, want valid=1 addr=%h len=%0d",
                             m_axi_arvalid, m_axi_araddr, m_axi_arlen, hold_addr, hold_len);
                else n_pass++;
            end
            ar_wait = m_axi_arvalid && !m_axi_arready;
            hold_addr = m_axi_araddr;
            hold_len  = m_axi_arlen;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_q.push_back({m_axi_araddr, m_axi_arlen});
                n_checks++;
                if ({m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arlock, m_axi_arcache,
                     m_axi_arprot, m_axi_arqos} !== {3'd5, 2'b01, 1'b0, 1'b0, 4'b0011, 3'd0, 4'd0})
                    $display("FAIL ar_const: got size=%0d burst=%0d id=%b lock=%b cache=%h prot=%0d qos=%0d, want 5 1 0 0 3 0 0",
                             m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arlock, m_axi_arcache,
                             m_axi_arprot, m_axi_arqos);
                else n_pass++;
                s_addr = m_axi_araddr;
                s_left = int'(m_axi_arlen) + 1;
                s_pending = 1;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                last_cyc = cyc;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                s_addr += 32'(BYTES);
                s_left--;
                cmd_beat++;
                s_hold = 0;
                if (s_left == 0) s_active = 0;
            end
        end
    end

    task automatic start_cmd(input logic [31:0] a, input int len);
        for (int g = 0; g < 200 && !cmd_ready; g++) @(negedge clk);
        ar_q.delete(); got_data.delete(); got_last.delete();
        done_cnt = 0; cmd_beat = 0; saw_arvalid = 0; bp_leak = 0;
        @(negedge clk); #2;
        cmd_valid = 1; cmd_addr = a; cmd_len = LEN_W'(len);
        @(negedge clk); #2;
        cmd_valid = 0;
    endtask

    task automatic run_cmd(input logic [31:0] a, input int len, input int bp_at, output bit ok);
        bit fired = 0;
        build_expect(a, len);
        start_cmd(a, len);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(negedge clk); #2;
            if (bp_at >= 0 && !fired && got_data.size() >= bp_at) begin bp_cnt = 10; fired = 1; end
        end
        ok = (done_cnt > 0);
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        resetn = 0; cmd_valid = 0; cmd_addr = 0; cmd_len = 0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if ({cmd_ready, m_axi_arvalid, done, err, out_valid, m_axi_araddr, m_axi_arlen} !== {5'b10000, 32'h0, 8'h0})
            $display("FAIL reset_state: got rdy=%b arv=%b done=%b err=%b ov=%b araddr=%h arlen=%0d, want 1 0 0 0 0 0 0",
                     cmd_ready, m_axi_arvalid, done, err, out_valid, m_axi_araddr, m_axi_arlen);
        else n_pass++;
        resetn = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bursts();
        logic [31:0] addrs[8];
        int          lens[8];
        bit          ok;
        addrs = '{32'h1000, 32'h0, 32'hF80, 32'hFFFF_FFC0, 0, 0, 0, 0};
        lens  = '{5, 40, 8, 4, 0, 0, 0, 0};
        for (int c = 4; c < 8; c++) begin
            addrs[c] = $urandom & 32'h0003_FFFF;
            lens[c]  = $urandom_range(1, 60);
        end
        for (int c = 0; c < 8; c++) begin
            run_cmd(addrs[c], lens[c], -1, ok);
            n_checks++;
            if (!ok) $display("FAIL burst%0d_timeout: got no done, want done", c); else n_pass++;
            n_checks++;
            if (ar_q.size() !== exp_ar.size())
                $display("FAIL burst%0d_ar_count: got %0d, want %0d", c, ar_q.size(), exp_ar.size());
            else n_pass++;
            for (int i = 0; i < exp_ar.size() && i < ar_q.size(); i++) begin
                n_checks++;
                if (ar_q[i] !== exp_ar[i])
                    $display("FAIL burst%0d_ar%0d: got addr=%h len=%0d, want addr=%h len=%0d",
                             c, i, ar_q[i].addr, ar_q[i].len, exp_ar[i].addr, exp_ar[i].len);
                else n_pass++;
            end
            n_checks++;
            if (got_data.size() !== exp_data.size())
                $display("FAIL burst%0d_beat_count: got %0d, want %0d", c, got_data.size(), exp_data.size());
            else n_pass++;
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                n_checks++;
                if ({got_last[i], got_data[i]} !== {(i == lens[c] - 1), exp_data[i]})
                    $display("FAIL burst%0d_beat%0d: got last=%b data=%h, want last=%b data=%h",
                             c, i, got_last[i], got_data[i], (i == lens[c] - 1), exp_data[i]);
                else n_pass++;
            end
            n_checks++;
            if ({done_cnt, done_cyc, err} !== {32'd1, last_cyc + 1, 1'b0})
                $display("FAIL burst%0d_done: got count=%0d cyc=%0d err=%b, want count=1 cyc=%0d err=0",
                         c, done_cnt, done_cyc, err, last_cyc + 1);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        run_cmd(32'h2000, 30, 5, ok);
        n_checks++;
        if (!ok) $display("FAIL bp_timeout: got no done, want done"); else n_pass++;
        n_checks++;
        if (bp_leak !== 0) $display("FAIL bp_rready: got %0d stalled cycles with rready, want 0", bp_leak);
        else n_pass++;
        n_checks++;
        if (got_data.size() !== exp_data.size())
            $display("FAIL bp_beat_count: got %0d, want %0d", got_data.size(), exp_data.size());
        else n_pass++;
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i])
                $display("FAIL bp_beat%0d: got %h, want %h", i, got_data[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        int resp_idx[3] = '{2, -1, -1};
        int last_idx[3] = '{-1, 0, 3};
        int lens[3]     = '{5, 4, 4};
        bit ok;
        for (int c = 0; c < 3; c++) begin
            inj_resp_idx = resp_idx[c];
            inj_last_idx = last_idx[c];
            run_cmd(32'h5000 + 32'(c * 32'h100), lens[c], -1, ok);
            inj_resp_idx = -1;
            inj_last_idx = -1;
            n_checks++;
            if ({ok, err, got_data.size()} !== {1'b1, 1'b1, lens[c]})
                $display("FAIL err%0d_flag: got done=%b err=%b beats=%0d, want 1 1 %0d",
                         c, ok, err, got_data.size(), lens[c]);
            else n_pass++;
            repeat (5) @(negedge clk);
            #2;
            n_checks++;
            if (err !== 1'b1) $display("FAIL err%0d_sticky: got %b, want 1", c, err); else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        start_cmd(32'h7000, 0);
        n_checks++;
        if ({done, cmd_ready, err} !== 3'b110)
            $display("FAIL zero_done: got done=%b rdy=%b err=%b, want 1 1 0", done, cmd_ready, err);
        else n_pass++;
        @(negedge clk); #2;
        n_checks++;
        if (done !== 1'b0) $display("FAIL zero_pulse: got %b, want 0", done); else n_pass++;
        repeat (5) @(negedge clk);
        #2;
        n_checks++;
        if ({saw_arvalid, done_cnt} !== {1'b0, 32'd1})
            $display("FAIL zero_no_ar: got arvalid_seen=%b done_count=%0d, want 0 1", saw_arvalid, done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_cmd(32'h3000, 40);
        for (int i = 0; i < 1000 && got_data.size() < 5; i++) @(negedge clk);
        @(negedge clk); #3;
        resetn = 0;
        #1;
        n_checks++;
        if ({m_axi_arvalid, out_valid, cmd_ready} !== 3'b001)
            $display("FAIL rst_mid_now: got arv=%b ov=%b rdy=%b, want 0 0 1", m_axi_arvalid, out_valid, cmd_ready);
        else n_pass++;
        @(negedge clk); #2;
        n_checks++;
        if ({m_axi_arvalid, out_valid, cmd_ready, done} !== 4'b0010)
            $display("FAIL rst_mid_next: got arv=%b ov=%b rdy=%b done=%b, want 0 0 1 0",
                     m_axi_arvalid, out_valid, cmd_ready, done);
        else n_pass++;
        resetn = 1;
        run_cmd(32'h4000, 20, -1, ok);
        n_checks++;
        if ({ok, err, got_data.size(), ar_q.size()} !== {1'b1, 1'b0, 32'd20, exp_ar.size()})
            $display("FAIL rst_after: got done=%b err=%b beats=%0d ars=%0d, want 1 0 20 %0d",
                     ok, err, got_data.size(), ar_q.size(), exp_ar.size());
        else n_pass++;
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== exp_data[i])
                $display("FAIL rst_after_beat%0d: got %h, want %h", i, got_data[i], exp_data[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bursts();
        test_backpressure();
        test_errors();
        test_zero_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
